// File: rtl/tick_generator_if.sv
// Control and output bundle for tick_generator: divisor programming, per-channel
// enable/clear, global sync, and the tick/square/refresh outputs.
interface tick_generator_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    // div_load is a single-cycle write strobe with no ready: every cycle it is high,
    // div_value is taken for channel div_sel (ignored when div_sel >= NUM_CH).
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clr;
    logic              sync;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_value;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic              refresh_clk;
    logic              refresh_tick;

    modport master (
        output en, clr, sync, div_load, div_sel, div_value,
        input  tick, sq, refresh_clk, refresh_tick
    );

    modport slave (
        input  en, clr, sync, div_load, div_sel, div_value,
        output tick, sq, refresh_clk, refresh_tick
    );
endinterface

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: per-channel divide-by-d tick and square
// wave, global phase sync, and a free-running display refresh divider.
module tick_generator #(
    parameter int                 NUM_CH      = 2,
    parameter int                 CNT_W       = 32,
    parameter logic [CNT_W-1:0]   DEFAULT_DIV = CNT_W'(1_000_000),
    parameter int                 REFRESH_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    tick_generator_if.slave bus
);
    logic [CNT_W-1:0]     cnt_q  [NUM_CH];
    logic [CNT_W-1:0]     div_q  [NUM_CH];
    logic [CNT_W-1:0]     last   [NUM_CH];
    logic [NUM_CH-1:0]    tick_q;
    logic [NUM_CH-1:0]    sq_q;
    logic [REFRESH_W-1:0] rcnt_q;
    logic [REFRESH_W-1:0] rcnt_next;
    logic                 rtick_q;

    // Terminal count is d-1 where a programmed zero behaves as a divisor of one.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            last[i] = (div_q[i] == '0) ? '0 : (div_q[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEFAULT_DIV;
            end
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Load applies even when a clear or sync wins the counter update.
                if (bus.div_load && (int'(bus.div_sel) == i)) begin
                    div_q[i] <= bus.div_value;
                end
                if (bus.sync || bus.clr[i]) begin
                    cnt_q[i]  <= '0;
                    sq_q[i]   <= 1'b0;
                    tick_q[i] <= 1'b0;
                end else if (bus.div_load && (int'(bus.div_sel) == i)) begin
                    cnt_q[i]  <= '0;
                    tick_q[i] <= 1'b0;
                end else if (!bus.en[i]) begin
                    tick_q[i] <= 1'b0;
                end else if (cnt_q[i] == last[i]) begin
                    cnt_q[i]  <= '0;
                    tick_q[i] <= 1'b1;
                    sq_q[i]   <= ~sq_q[i];
                end else begin
                    cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rcnt_next = rcnt_q + REFRESH_W'(1);

    // Refresh divider ignores sync/clr; the pulse coincides with the MSB rising.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt_q  <= '0;
            rtick_q <= 1'b0;
        end else begin
            rcnt_q  <= rcnt_next;
            rtick_q <= rcnt_next[REFRESH_W-1] & ~rcnt_q[REFRESH_W-1];
        end
    end

    assign bus.tick         = tick_q;
    assign bus.sq           = sq_q;
    assign bus.refresh_clk  = rcnt_q[REFRESH_W-1];
    assign bus.refresh_tick = rtick_q;
endmodule

// File: tb/tb_tick_generator.sv
// Self-checking bench for tick_generator: fixed vector table, hand-written corner
// sequences, and randomized traffic against a modulo-arithmetic reference model.
module tb_tick_generator;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int REFRESH_W   = 4;
  localparam int RPER        = 1 << REFRESH_W;

  logic clk;
  logic reset;

  tick_generator_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_if ();

  tick_generator #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(CNT_W'(DEFAULT_DIV)),
    .REFRESH_W(REFRESH_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: enabled cycles since restart, ticks since clear
  int m_div     [NUM_CH];
  int m_elapsed [NUM_CH];
  int m_ticks   [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  int m_cyc;

  logic [5:0] exp_q[$];

  typedef struct {
    logic [1:0] en;
    logic [1:0] clr;
    logic       sync;
    logic       load;
    logic       sel;
    logic [7:0] val;
    logic [1:0] tick;
    logic [1:0] sq;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [1:0] e, input logic [1:0] c,
                            input logic s, input logic l, input logic sel,
                            input logic [7:0] v);
    logic [1:0] esq;
    logic       hit;
    int         d;
    if (rst) begin
      m_cyc = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DEFAULT_DIV;
        m_elapsed[i] = 0;
        m_ticks[i] = 0;
      end
      m_tick = '0;
    end else begin
      m_cyc++;
      for (int i = 0; i < NUM_CH; i++) begin
        hit = l && (int'(sel) == i);
        if (hit) m_div[i] = int'(v);
        if (s || c[i]) begin
          m_elapsed[i] = 0;
          m_ticks[i] = 0;
          m_tick[i] = 1'b0;
        end else if (hit) begin
          m_elapsed[i] = 0;
          m_tick[i] = 1'b0;
        end else if (!e[i]) begin
          m_tick[i] = 1'b0;
        end else begin
          d = (m_div[i] == 0) ? 1 : m_div[i];
          m_elapsed[i]++;
          m_tick[i] = ((m_elapsed[i] % d) == 0);
          if (m_tick[i]) m_ticks[i]++;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) esq[i] = m_ticks[i][0];
    exp_q.push_back({((m_cyc % RPER) == RPER / 2), ((m_cyc % RPER) >= RPER / 2), esq, m_tick});
  endtask

  // driver: inputs driven away from the edge, outputs sampled #1 after it
  task automatic apply_cycle(input logic rst, input logic [1:0] e, input logic [1:0] c,
                             input logic s, input logic l, input logic sel,
                             input logic [7:0] v);
    logic [5:0] exp;
    reset = rst;
    bus_if.en = e;
    bus_if.clr = c;
    bus_if.sync = s;
    bus_if.div_load = l;
    bus_if.div_sel = sel;
    bus_if.div_value = v;
    @(posedge clk);
    #1;
    model_step(rst, e, c, s, l, sel, v);
    exp = exp_q.pop_front();
    check("tick", 32'(bus_if.tick), 32'(exp[1:0]));
    check("sq", 32'(bus_if.sq), 32'(exp[3:2]));
    check("refresh_clk", 32'(bus_if.refresh_clk), 32'(exp[4]));
    check("refresh_tick", 32'(bus_if.refresh_tick), 32'(exp[5]));
  endtask

  task automatic idle(input logic [1:0] e);
    apply_cycle(1'b0, e, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    apply_cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_tick", 32'(bus_if.tick), 32'd0);
    check("reset_sq", 32'(bus_if.sq), 32'd0);
    check("reset_refresh", 32'({bus_if.refresh_clk, bus_if.refresh_tick}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.en = '0;
    bus_if.clr = '0;
    bus_if.sync = 1'b0;
    bus_if.div_load = 1'b0;
    bus_if.div_sel = '0;
    bus_if.div_value = '0;

    // en, clr, sync, load, sel, val, exp tick, exp sq (bit0 = channel 0)
    vecs[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[1]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[2]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[3]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11};
    vecs[4]  = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 8'd3, 2'b00, 2'b11};
    vecs[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11};
    vecs[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11};
    vecs[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b00};
    vecs[8]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[9]  = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[10] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01};
    vecs[12] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b10, 2'b11};
    vecs[13] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'b00, 2'b10};
    vecs[14] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[15] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0, 2'b00, 2'b00};
    vecs[16] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01};
    vecs[17] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b10};
    vecs[18] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b11};
    vecs[19] = '{2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1, 2'b00, 2'b10};
    vecs[20] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01};
    vecs[21] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 8'd2, 2'b00, 2'b00};
    vecs[22] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01};
    vecs[23] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'b11, 2'b10};

    @(negedge clk);
    do_reset();
    for (int k = 0; k < 24; k++) begin
      apply_cycle(1'b0, vecs[k].en, vecs[k].clr, vecs[k].sync, vecs[k].load,
                  vecs[k].sel, vecs[k].val);
      check($sformatf("vec%0d_tick", k), 32'(bus_if.tick), 32'(vecs[k].tick));
      check($sformatf("vec%0d_sq", k), 32'(bus_if.sq), 32'(vecs[k].sq));
    end

    // enable gap on ch0 at cnt=2: tick 2 enabled cycles after re-enable
    do_reset();
    idle(2'b11);
    idle(2'b11);
    for (int k = 0; k < 5; k++) begin
      idle(2'b10);
      check("gap_hold_tick0", 32'(bus_if.tick[0]), 32'd0);
    end
    idle(2'b11);
    check("gap_resume1_tick0", 32'(bus_if.tick[0]), 32'd0);
    idle(2'b11);
    check("gap_resume2_tick0", 32'(bus_if.tick[0]), 32'd1);

    // sync with ch0 at cnt=1, ch1 at cnt=2: aligned tick 4 cycles later
    do_reset();
    idle(2'b10);
    idle(2'b11);
    apply_cycle(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    check("sync_sq", 32'(bus_if.sq), 32'd0);
    check("sync_tick", 32'(bus_if.tick), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(2'b11);
      check($sformatf("sync_edge%0d_tick", k), 32'(bus_if.tick), (k == 4) ? 32'd3 : 32'd0);
    end

    // refresh timing from reset, then reset mid-run
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      idle(2'b11);
      if (k == 7) check("refresh_tick_e7", 32'(bus_if.refresh_tick), 32'd0);
      if (k == 8) check("refresh_e8", 32'({bus_if.refresh_clk, bus_if.refresh_tick}), 32'd3);
      if (k == 9) check("refresh_e9", 32'({bus_if.refresh_clk, bus_if.refresh_tick}), 32'd2);
      if (k == 16) check("refresh_clk_e16", 32'(bus_if.refresh_clk), 32'd0);
      if (k == 24) check("refresh_tick_e24", 32'(bus_if.refresh_tick), 32'd1);
    end
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      idle(2'b11);
      check($sformatf("post_reset_e%0d_tick", k), 32'(bus_if.tick), (k == 4) ? 32'd3 : 32'd0);
    end

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      apply_cycle(1'b0,
                  2'($urandom_range(0, 3) != 0 ? 3 : $urandom_range(0, 3)),
                  2'($urandom_range(0, 19) == 0 ? $urandom_range(1, 3) : 0),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 14) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
